// File: rtl/map_pkg.sv
// Shared battlefield constants, colours and the VGA timing bundle used by
// every overlay stage of the map pipeline.
package map_pkg;

  localparam int FIELD_XMIN = 2;
  localparam int FIELD_XMAX = 766;
  localparam int FIELD_YMIN = 2;
  localparam int FIELD_YMAX = 765;

  localparam int TANK_W = 32;
  localparam int TANK_H = 32;

  localparam logic [11:0] BLACK       = 12'h000;
  localparam logic [11:0] KEY_COLOR   = 12'hF0F;
  localparam logic [11:0] OUTLINE_RED = 12'hF00;

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  function automatic logic [10:0] clampU11(input logic [10:0] val,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth shift-register delay line; synchronous reset clears every tap.
// DEPTH of zero degenerates to a plain wire.
module signal_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst;
      assign data_o = data_i;
    end else begin : g_taps
      logic [WIDTH-1:0] taps_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
        end else begin
          taps_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
        end
      end

      assign data_o = taps_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/draw_tank_overlay.sv
// Overlays the player-tank sprite onto the map colour stream and realigns timing.
// Optional HITBOX_OUTLINE_EN paints the 1-px sprite-box perimeter red.
module draw_tank_overlay #(
  parameter int          TANK_W      = map_pkg::TANK_W,
  parameter int          TANK_H      = map_pkg::TANK_H,
  parameter int          MAP_LATENCY = 2,
  parameter logic [11:0] KEY_COLOR   = map_pkg::KEY_COLOR,
  parameter int          FIELD_XMAX  = map_pkg::FIELD_XMAX,
  parameter int          FIELD_YMAX  = map_pkg::FIELD_YMAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos_in,
  input  logic [9:0]  ypos_in,
  input  logic        pos_valid,
  output logic [9:0]  pixel_addr,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  import map_pkg::*;

  localparam int          RELXW = $clog2(TANK_W);
  localparam int          RELYW = $clog2(TANK_H);
  localparam logic [10:0] XLO   = 11'(FIELD_XMIN);
  localparam logic [10:0] XHI   = 11'(FIELD_XMAX - TANK_W + 1);
  localparam logic [10:0] YLO   = 11'(FIELD_YMIN);
  localparam logic [10:0] YHI   = 11'(FIELD_YMAX - TANK_H + 1);
  localparam logic [10:0] TW_M1 = 11'(TANK_W - 1);
  localparam logic [10:0] TH_M1 = 11'(TANK_H - 1);

`ifdef HITBOX_OUTLINE_EN
  localparam int FLAGW = 2;
`else
  localparam int FLAGW = 1;
`endif

  logic [10:0] pendX_q, pendX_d, actX_q, actX_d;
  logic [9:0]  pendY_q, pendY_d, actY_q, actY_d;
  logic        vblnkPrev_q;

  // Pending follows the strobe; active only copies pending on the vblank rising
  // edge so a frame is never drawn with two different tank positions.
  always_comb begin
    pendX_d = pendX_q;
    pendY_d = pendY_q;
    actX_d  = actX_q;
    actY_d  = actY_q;
    if (pos_valid) begin
      pendX_d = clampU11(xpos_in, XLO, XHI);
      pendY_d = 10'(clampU11({1'b0, ypos_in}, YLO, YHI));
    end
    if (vblnk_in && !vblnkPrev_q) begin
      actX_d = pendX_q;
      actY_d = pendY_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pendX_q     <= XLO;
      pendY_q     <= 10'(YLO);
      actX_q      <= XLO;
      actY_q      <= 10'(YLO);
      vblnkPrev_q <= 1'b0;
    end else begin
      pendX_q     <= pendX_d;
      pendY_q     <= pendY_d;
      actX_q      <= actX_d;
      actY_q      <= actY_d;
      vblnkPrev_q <= vblnk_in;
    end
  end

  logic [10:0]      vcountExt, actYExt;
  logic             inBox;
  logic [RELXW-1:0] relX;
  logic [RELYW-1:0] relY;
  logic [9:0]       pixelAddr_d, pixelAddr_q;
  logic [FLAGW-1:0] flags_d, flags_q, flagsAl;

  // Box test stays in full 11-bit unsigned width; the relative offsets are only
  // narrowed once a pixel is known to be inside the sprite.
  always_comb begin
    vcountExt   = {1'b0, vcount_in};
    actYExt     = {1'b0, actY_q};
    inBox       = (hcount_in >= actX_q) && (hcount_in <= actX_q + TW_M1) &&
                  (vcountExt >= actYExt) && (vcountExt <= actYExt + TH_M1);
    relX        = RELXW'(hcount_in - actX_q);
    relY        = RELYW'(vcountExt - actYExt);
    pixelAddr_d = '0;
    flags_d     = '0;
    if (inBox) begin
      pixelAddr_d = 10'(relY * TANK_W) + 10'(relX);
      flags_d[0]  = 1'b1;
`ifdef HITBOX_OUTLINE_EN
      flags_d[1]  = (relX == '0) || (relX == RELXW'(TANK_W - 1)) ||
                    (relY == '0) || (relY == RELYW'(TANK_H - 1));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixelAddr_q <= '0;
      flags_q     <= '0;
    end else begin
      pixelAddr_q <= pixelAddr_d;
      flags_q     <= flags_d;
    end
  end

  assign pixel_addr = pixelAddr_q;

  timing_t     timingIn, timingAl, timingOut_q;
  logic [11:0] romAl, rgb_d, rgb_q;

  assign timingIn = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  signal_delay #(.WIDTH($bits(timing_t)), .DEPTH(MAP_LATENCY)) u_timingDelay (
    .clk    (clk),
    .rst    (rst),
    .data_i (timingIn),
    .data_o (timingAl)
  );

  signal_delay #(.WIDTH(12), .DEPTH(MAP_LATENCY - 2)) u_romDelay (
    .clk    (clk),
    .rst    (rst),
    .data_i (rgb_pixel),
    .data_o (romAl)
  );

  signal_delay #(.WIDTH(FLAGW), .DEPTH(MAP_LATENCY - 1)) u_flagDelay (
    .clk    (clk),
    .rst    (rst),
    .data_i (flags_q),
    .data_o (flagsAl)
  );

  // Blanking beats everything, then the outline (if built), then opaque sprite.
  always_comb begin
    rgb_d = rgb_in;
    if (timingAl.hblnk || timingAl.vblnk) begin
      rgb_d = BLACK;
    end
`ifdef HITBOX_OUTLINE_EN
    else if (flagsAl[1]) begin
      rgb_d = OUTLINE_RED;
    end
`endif
    else if (flagsAl[0] && (romAl != KEY_COLOR)) begin
      rgb_d = romAl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q       <= '0;
      timingOut_q <= '0;
    end else begin
      rgb_q       <= rgb_d;
      timingOut_q <= timingAl;
    end
  end

  assign rgb_out    = rgb_q;
  assign hcount_out = timingOut_q.hcount;
  assign vcount_out = timingOut_q.vcount;
  assign hsync_out  = timingOut_q.hsync;
  assign vsync_out  = timingOut_q.vsync;
  assign hblnk_out  = timingOut_q.hblnk;
  assign vblnk_out  = timingOut_q.vblnk;

endmodule

// File: tb/tb_draw_tank_overlay.sv
// Self-checking bench for draw_tank_overlay: directed probe table, shadow/clamp
// sequences and randomized traffic against a pixel-level reference model.
module tb_draw_tank_overlay;
  import map_pkg::*;

  localparam int LAT = 2;
  localparam int TW  = 32;
  localparam int TH  = 32;
  localparam int XHI = 735;
  localparam int YHI = 734;
`ifdef HITBOX_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  logic        clk, rst;
  logic [10:0] hcount_in, xpos_in, hcount_out;
  logic [9:0]  vcount_in, ypos_in, vcount_out, pixel_addr;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, pos_valid;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_pixel, rgb_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  draw_tank_overlay dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .pos_valid  (pos_valid),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // Synchronous sprite ROM: data shows up one cycle after the address.
  logic [11:0] romMem [1024];
  always @(posedge clk) rgb_pixel <= romMem[pixel_addr];

  int checks = 0;
  int errors = 0;

  int          mPendX, mPendY, mActX, mActY;
  bit          mPrevVb;
  bit          mapRandom;
  logic [11:0] mapSeed;

  typedef struct {
    logic [11:0] rgb;
    logic [24:0] timing;
  } exp_t;
  exp_t        expQ[$];
  logic [11:0] mapHist[$];

  typedef struct {
    bit          move;
    int          px, py, h, v;
    bit          hb;
    logic [9:0]  addr;
    logic [11:0] rgb, rgbOl;
  } probe_t;
  probe_t probes[15];

  function automatic logic [11:0] mapColor(input int h, input int v);
    if (!mapRandom) return 12'hEC1;
    return 12'((h * 37) ^ (v * 91)) ^ mapSeed;
  endfunction

  function automatic int clampInt(input int val, input int lo, input int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One pixel clock: drive inputs, predict from the model, then compare.
  task automatic applyStimulus(input int h, input int v, input bit hs, input bit vs,
                               input bit hb, input bit vb, input bit pv,
                               input int px, input int py, input bit r);
    exp_t        e;
    int          relX, relY;
    bit          inBox, onEdge;
    logic [9:0]  expAddr;
    logic [11:0] romVal, col;
    rst       = r;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    pos_valid = pv;
    xpos_in   = 11'(px);
    ypos_in   = 10'(py);
    mapHist.push_back(mapColor(h, v));
    if (mapHist.size() > LAT + 1) void'(mapHist.pop_front());
    rgb_in = (mapHist.size() == LAT + 1) ? mapHist[0] : 12'h000;

    inBox   = (h >= mActX) && (h < mActX + TW) && (v >= mActY) && (v < mActY + TH);
    relX    = h - mActX;
    relY    = v - mActY;
    expAddr = inBox ? 10'(relY * TW + relX) : 10'd0;
    onEdge  = inBox && (relX == 0 || relX == TW - 1 || relY == 0 || relY == TH - 1);
    romVal  = romMem[expAddr];
    if (hb || vb)                                   col = 12'h000;
    else if (OUTLINE && onEdge)                     col = 12'hF00;
    else if (inBox && romVal != map_pkg::KEY_COLOR) col = romVal;
    else                                            col = mapColor(h, v);
    e.rgb    = col;
    e.timing = {11'(h), 10'(v), hs, vs, hb, vb};

    if (r) begin
      mPendX = 2; mPendY = 2; mActX = 2; mActY = 2; mPrevVb = 1'b0;
      expQ.delete();
    end else begin
      expQ.push_back(e);
      if (vb && !mPrevVb) begin
        mActX = mPendX;
        mActY = mPendY;
      end
      if (pv) begin
        mPendX = clampInt(px, 2, XHI);
        mPendY = clampInt(py, 2, YHI);
      end
      mPrevVb = vb;
    end

    @(posedge clk);
    #1;
    if (r) begin
      checkOutput("reset_rgb", {20'd0, rgb_out}, 32'd0);
      checkOutput("reset_addr", {22'd0, pixel_addr}, 32'd0);
      checkOutput("reset_timing", {7'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                                   hblnk_out, vblnk_out}, 32'd0);
    end else begin
      checkOutput("pixel_addr", {22'd0, pixel_addr}, {22'd0, expAddr});
      if (expQ.size() > LAT) begin
        e = expQ.pop_front();
        checkOutput("rgb_out", {20'd0, rgb_out}, {20'd0, e.rgb});
        checkOutput("timing_out", {7'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                                   hblnk_out, vblnk_out}, {7'd0, e.timing});
      end else begin
        checkOutput("warmup_timing", {7'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                                      hblnk_out, vblnk_out}, 32'd0);
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic setVblank(input bit vb, input bit pv, input int px, input int py);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, vb, pv, px, py, 1'b0);
  endtask

  task automatic moveTank(input int px, input int py);
    setVblank(1'b0, 1'b1, px, py);
    setVblank(1'b1, 1'b0, 0, 0);
    setVblank(1'b0, 1'b0, 0, 0);
  endtask

  task automatic probePixel(input int h, input int v, input bit hb,
                            output logic [9:0] addr, output logic [11:0] col);
    applyStimulus(h, v, 1'b1, 1'b0, hb, 1'b0, 1'b0, 0, 0, 1'b0);
    addr = pixel_addr;
    repeat (LAT) idleCycle();
    col = rgb_out;
  endtask

  logic [9:0]  gotAddr;
  logic [11:0] gotRgb;
  bit          vbState;
  int          rh, rv;

  initial begin
    mapRandom = 1'b0;
    mapSeed   = 12'h000;
    mPendX = 2; mPendY = 2; mActX = 2; mActY = 2; mPrevVb = 1'b0;
    for (int i = 0; i < 1024; i++) romMem[i] = 12'h150;
    romMem[5] = map_pkg::KEY_COLOR;

    //            move  px   py   h    v    hb  addr   rgb      rgbOl
    probes[0]  = '{1'b1, 100, 200, 100, 200, 1'b0, 10'd0,    12'h150, 12'hF00};
    probes[1]  = '{1'b0, 0,   0,   131, 231, 1'b0, 10'd1023, 12'h150, 12'hF00};
    probes[2]  = '{1'b0, 0,   0,   99,  200, 1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[3]  = '{1'b0, 0,   0,   132, 200, 1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[4]  = '{1'b0, 0,   0,   100, 199, 1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[5]  = '{1'b0, 0,   0,   100, 232, 1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[6]  = '{1'b0, 0,   0,   105, 200, 1'b0, 10'd5,    12'hEC1, 12'hF00};
    probes[7]  = '{1'b0, 0,   0,   110, 205, 1'b0, 10'd170,  12'h150, 12'h150};
    probes[8]  = '{1'b0, 0,   0,   115, 210, 1'b1, 10'd335,  12'h000, 12'h000};
    probes[9]  = '{1'b0, 0,   0,   100, 215, 1'b0, 10'd480,  12'h150, 12'hF00};
    probes[10] = '{1'b1, 760, 1,   735, 2,   1'b0, 10'd0,    12'h150, 12'hF00};
    probes[11] = '{1'b0, 0,   0,   766, 33,  1'b0, 10'd1023, 12'h150, 12'hF00};
    probes[12] = '{1'b0, 0,   0,   734, 2,   1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[13] = '{1'b0, 0,   0,   767, 33,  1'b0, 10'd0,    12'hEC1, 12'hEC1};
    probes[14] = '{1'b0, 0,   0,   735, 34,  1'b0, 10'd0,    12'hEC1, 12'hEC1};

    $display("[TB] reset during active video");
    for (int i = 0; i < 4; i++)
      applyStimulus(10 + i, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 400, 400, 1'b1);
    applyStimulus(50, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(51, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(52, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("reset_lag_hcount", {21'd0, hcount_out}, 32'd50);
    checkOutput("reset_lag_hsync", {31'd0, hsync_out}, 32'd1);

    $display("[TB] shadow register update");
    moveTank(100, 200);
    applyStimulus(0, 400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 300, 1'b0);
    probePixel(110, 210, 1'b0, gotAddr, gotRgb);
    checkOutput("shadow_old_frame", {20'd0, gotRgb}, 32'h150);
    probePixel(310, 310, 1'b0, gotAddr, gotRgb);
    checkOutput("shadow_not_yet", {20'd0, gotRgb}, 32'hEC1);
    setVblank(1'b1, 1'b1, 500, 500);
    setVblank(1'b0, 1'b0, 0, 0);
    probePixel(310, 310, 1'b0, gotAddr, gotRgb);
    checkOutput("shadow_new_frame", {20'd0, gotRgb}, 32'h150);
    checkOutput("shadow_new_addr", {22'd0, gotAddr}, 32'd330);
    probePixel(510, 510, 1'b0, gotAddr, gotRgb);
    checkOutput("shadow_edge_strobe_deferred", {20'd0, gotRgb}, 32'hEC1);
    setVblank(1'b1, 1'b0, 0, 0);
    setVblank(1'b0, 1'b0, 0, 0);
    probePixel(510, 510, 1'b0, gotAddr, gotRgb);
    checkOutput("shadow_edge_strobe_applied", {20'd0, gotRgb}, 32'h150);

    $display("[TB] directed probe table");
    for (int i = 0; i < 15; i++) begin
      if (probes[i].move) moveTank(probes[i].px, probes[i].py);
      probePixel(probes[i].h, probes[i].v, probes[i].hb, gotAddr, gotRgb);
      checkOutput($sformatf("table%0d_addr", i), {22'd0, gotAddr}, {22'd0, probes[i].addr});
      checkOutput($sformatf("table%0d_rgb", i), {20'd0, gotRgb},
                  {20'd0, OUTLINE ? probes[i].rgbOl : probes[i].rgb});
    end

    $display("[TB] randomized traffic");
    repeat (4) idleCycle();
    for (int i = 0; i < 1024; i++)
      romMem[i] = ($urandom_range(0, 7) == 0) ? map_pkg::KEY_COLOR : 12'($urandom);
    mapRandom = 1'b1;
    mapSeed   = 12'($urandom);
    vbState   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) vbState = ~vbState;
      if ($urandom_range(0, 3) == 0) begin
        rh = $urandom_range(0, 799);
        rv = $urandom_range(0, 599);
      end else begin
        rh = mActX - 2 + $urandom_range(0, 35);
        rv = mActY - 2 + $urandom_range(0, 35);
      end
      applyStimulus(rh, rv, 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
                    vbState, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2047), $urandom_range(0, 1023),
                    i >= 1500 && i < 1503);
    end
    repeat (4) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_tank_overlay.md
Name: draw_tank_overlay

Overview:
- Video-pipeline stage directly downstream of the battlefield map renderer.
- Takes raw VGA timing plus the map's RGB (which arrives MAP_LATENCY cycles after its timing) and overlays a 32x32 player-tank sprite read from an external synchronous ROM.
- Realigns timing with colour and re-emits both, so the next overlay stage sees a coherent bus.

Parameters:
- TANK_W, 32, sprite width in pixels.
- TANK_H, 32, sprite height in pixels.
- MAP_LATENCY, 2, cycles by which rgb_in lags timing inputs; must be >= 2.
- KEY_COLOR, 12'hF0F, sprite colour treated as transparent.
- FIELD_XMAX, 766, last battlefield column.
- FIELD_YMAX, 765, last battlefield row.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  10  vertical line counter
- hsync_in, vsync_in  in  1 each  syncs
- hblnk_in, vblnk_in  in  1 each  blanking
- rgb_in  in  12  map colour, MAP_LATENCY cycles behind timing
- xpos_in  in  11  requested tank left column
- ypos_in  in  10  requested tank top row
- pos_valid  in  1  one-cycle strobe capturing xpos_in/ypos_in
- pixel_addr  out  10  sprite ROM address, registered
- rgb_pixel  in  12  ROM data, valid one cycle after pixel_addr
- hcount_out, vcount_out  out  11/10  timing delayed MAP_LATENCY+1
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed likewise
- rgb_out  out  12  composited colour, registered

Behaviour:
- Reset: all outputs 0.
  - pending_x = 2, pending_y = 2.
  - active_x = 2, active_y = 2.
  - Delay lines cleared.
  - Reset mid-frame discards all in-flight pixels.
- Position capture:
  - pos_valid=1 loads pending regs.
  - Clamp x to [2, FIELD_XMAX-TANK_W+1] = [2,735] and y to [2, FIELD_YMAX-TANK_H+1] = [2,734].
- Shadow update:
  - active <= pending only on the cycle vblnk_in rises (registered-edge detect), so there is no tearing mid-frame.
  - If pos_valid coincides with the vblnk edge, the old pending is transferred. The new value takes effect next frame.
- Stage T (raw timing):
  - in_box = hcount in [active_x, active_x+TANK_W-1] and vcount in [active_y, active_y+TANK_H-1].
  - rel_x = hcount-active_x, rel_y = vcount-active_y.
  - T+1: pixel_addr <= in_box ? rel_y*TANK_W+rel_x : 0.
  - in_box registered alongside.
- ROM data at T+2:
  - Delayed MAP_LATENCY-2 further cycles so it aligns with rgb_in. in_box is delayed identically.
- Composite, registered (output at T+MAP_LATENCY+1):
  - If delayed hblnk or vblnk: rgb_out = 0.
  - Else if in_box and rgb_pixel != KEY_COLOR: rgb_out = rgb_pixel.
  - Else: rgb_out = rgb_in.
- Timing outputs: all six delayed exactly MAP_LATENCY+1 cycles; hcount/vcount are never modified.
- Arithmetic: compares in 11 bits unsigned; rel_x/rel_y truncated to 5 bits only after the in_box test passes.

Optional Feature:
- Macro HITBOX_OUTLINE_EN.
- When defined, pixels on the 1-px perimeter of the sprite box (rel_x or rel_y equal to 0 or max) output 12'hF00 regardless of sprite/key. Blanking still wins.
- When undefined, no outline logic is synthesized.

Decomposition:
- Shared package map_pkg holds:
  - FIELD_XMIN/XMAX/YMIN/YMAX
  - colour constants (BLACK, KEY_COLOR, OUTLINE_RED)
  - TANK_W/TANK_H defaults
  - typedef for the timing bundle {hcount, vcount, hsync, vsync, hblnk, vblnk}
- One sub-module: signal_delay (params WIDTH, DEPTH; sync reset clears all taps). It is instantiated for the timing bundle, the ROM data and in_box.

Test Plan:
- Reset: hold rst during active video → rgb_out=0, pixel_addr=0, all timing outs 0. After release, first output appears exactly 3 cycles after inputs.
- Latency: map rgb_in=12'hEC1 everywhere, tank at (100,200), ROM returns 12'h150 → rgb_out=12'h150 for hcount 100..131 and vcount 200..231; 12'hEC1 elsewhere; hcount_out lags hcount_in by 3.
- Transparency: ROM returns KEY_COLOR at addr 5 → pixel (105,200) shows map colour 12'hEC1.
- Shadow update: pulse pos_valid with (300,300) at vcount 400 → current frame still draws at (100,200); next frame draws at (300,300).
- Clamp: xpos_in=760, ypos_in=1 → tank drawn at (735,2); pixel_addr at (735,2) = 0 and at (766,33) = 1023.
- Blanking: hblnk_in=1 inside the box region → rgb_out=0. With HITBOX_OUTLINE_EN, box edges at (100,200..231) = 12'hF00.
